mem_port_arbiter: RTL

Shares the single SRAM-like memory port between the fetch-side instruction requester (read-only) and the EX/MEM-side data requester (read/write).
- Tracks outstanding transactions in an in-order ID FIFO and routes each response back to its owner.
- Holds grant stability until address handshake.
- Swallows responses for instruction fetches cancelled by an exception or branch flush.
Sits between the core pipeline and the memory bridge.

---
 rtl/mem_port_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one SRAM-like port between fetch and data requesters and
//            routes in-order responses through an ID FIFO.
//            Optional ARB_ROUND_ROBIN_EN: round-robin tie break instead of
//            fixed DATA-over-INST priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        inst_cancel,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        proto_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(OUTSTANDING);
  localparam logic             c_id_inst  = 1'b0;
  localparam logic             c_id_data  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HOLD_INST = 2'd1,
    ST_HOLD_DATA = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_fifo_id   [OUTSTANDING];
  logic             r_fifo_disc [OUTSTANDING];
  logic             r_proto_err;
`ifdef ARB_ROUND_ROBIN_EN
  logic             r_last_data;
`endif

  logic w_full;
  logic w_empty;
  logic w_pick_data;
  logic w_sel_data;
  logic w_any;
  logic w_push;
  logic w_pop;
  logic w_head_id;
  logic w_head_disc;

  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie, the requester not granted last time wins
  assign w_pick_data = data_req && (!inst_req || !r_last_data);
`else
  assign w_pick_data = data_req;
`endif

  always_comb begin
    w_sel_data = 1'b0;
    w_any      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_any      = data_req | inst_req;
        w_sel_data = w_pick_data;
      end
      ST_HOLD_INST: w_any = 1'b1;
      ST_HOLD_DATA: begin
        w_any      = 1'b1;
        w_sel_data = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_req   = w_any & ~w_full & ~reset;
  assign mem_wr    = w_sel_data & data_wr;
  assign mem_size  = w_sel_data ? data_size  : 2'd2;
  assign mem_wstrb = w_sel_data ? data_wstrb : 4'd0;
  assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
  assign mem_wdata = w_sel_data ? data_wdata : 32'd0;

  assign w_push       = mem_req & mem_addr_ok;
  assign w_pop        = mem_data_ok & ~w_empty;
  assign inst_addr_ok = w_push & ~w_sel_data;
  assign data_addr_ok = w_push &  w_sel_data;

  assign w_head_id    = r_fifo_id[r_rptr];
  assign w_head_disc  = r_fifo_disc[r_rptr];
  // A cancel arriving with the head's response suppresses it as well
  assign inst_data_ok = w_pop & (w_head_id == c_id_inst) & ~w_head_disc & ~inst_cancel;
  assign data_data_ok = w_pop & (w_head_id == c_id_data);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign busy      = (r_count != '0) || (r_state != ST_IDLE);
  assign proto_err = r_proto_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mem_req && !mem_addr_ok)
            r_state <= w_sel_data ? ST_HOLD_DATA : ST_HOLD_INST;
        end
        ST_HOLD_INST, ST_HOLD_DATA: begin
          if (w_push) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_fifo_id[i]   <= c_id_inst;
        r_fifo_disc[i] <= 1'b0;
      end
    end else begin
      if (inst_cancel) begin
        for (int i = 0; i < OUTSTANDING; i++) begin
          if (r_fifo_id[i] == c_id_inst) r_fifo_disc[i] <= 1'b1;
        end
      end
      // The pushed entry overrides any stale cancel marking of its slot
      if (w_push) begin
        r_fifo_id[r_wptr]   <= w_sel_data ? c_id_data : c_id_inst;
        r_fifo_disc[r_wptr] <= ~w_sel_data & inst_cancel;
        r_wptr              <= (r_wptr == c_last_ptr) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last_ptr) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (mem_data_ok && w_empty) r_proto_err <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_data <= 1'b0;
    end else if (w_push) begin
      r_last_data <= w_sel_data;
    end
  end
`endif

endmodule
`default_nettype wire
